// File: rtl/program_stack_sequencer.sv
// program_stack_sequencer: turns stack commands into single-cycle push/pop strobes and tracks occupancy.
// Define PROGRAM_STACK_SEQ_EXT_OPS_EN to build SWAP/OVER sequencing; otherwise those ops are rejected.
//
// state | meaning
// IDLE  | ready for a command
// S1-S4 | access steps, at most one strobe each (S2-S4 only with extended ops)
// RESP  | one-cycle response
// FAULT | stack error seen; held until reset
module program_stack_sequencer #(
    parameter int WIDTH       = 18,
    parameter int STACK_DEPTH = 64,
    localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_data,
    output logic               cmd_ready,
    output logic               rsp_valid,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err,
    output logic               fault,
    output logic [DEPTH_W-1:0] depth,
    input  logic [WIDTH-1:0]   stk_top,
    input  logic               stk_empty,
    input  logic               stk_err,
    output logic [WIDTH-1:0]   stk_data,
    output logic               stk_push,
    output logic               stk_pop
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_DROP = 3'd4;
    localparam logic [2:0] OP_SWAP = 3'd5;
    localparam logic [2:0] OP_OVER = 3'd6;
    localparam logic [2:0] OP_PEEK = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        S1,
        RESP,
        FAULT
`ifdef PROGRAM_STACK_SEQ_EXT_OPS_EN
        , S2,
        S3,
        S4
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   a_q;
    logic               err_q;
    logic [DEPTH_W-1:0] depth_q;
    logic               accept, reject, latch_a;
    logic               need_one, need_two, need_room, ext_ok, cmd_legal;
`ifdef PROGRAM_STACK_SEQ_EXT_OPS_EN
    logic [WIDTH-1:0]   b_q;
    logic               latch_b;
`endif

    assign depth = depth_q;

    // Legality is judged purely on tracked occupancy so a rejected command never touches the stack.
    always_comb begin
        need_one  = (cmd_op == OP_POP) || (cmd_op == OP_DROP) || (cmd_op == OP_DUP) || (cmd_op == OP_PEEK);
        need_two  = (cmd_op == OP_SWAP) || (cmd_op == OP_OVER);
        need_room = (cmd_op == OP_PUSH) || (cmd_op == OP_DUP) || (cmd_op == OP_OVER);
`ifdef PROGRAM_STACK_SEQ_EXT_OPS_EN
        ext_ok = 1'b1;
`else
        ext_ok = !need_two;
`endif
        cmd_legal = ext_ok
                 && !(need_one && (depth_q == '0))
                 && !(need_two && (depth_q < DEPTH_W'(2)))
                 && !(need_room && (depth_q == DEPTH_W'(STACK_DEPTH)));
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        fault     = 1'b0;
        stk_data  = '0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        latch_a   = 1'b0;
`ifdef PROGRAM_STACK_SEQ_EXT_OPS_EN
        latch_b   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    reject  = !cmd_legal;
                    state_d = (reject || cmd_op == OP_NOP || cmd_op == OP_PEEK) ? RESP : S1;
                end
            end
            S1: begin
                state_d = RESP;
                case (op_q)
                    OP_PUSH: begin stk_push = 1'b1; stk_data = data_q; end
                    OP_POP:  begin stk_pop = 1'b1; latch_a = 1'b1; end
                    OP_DUP:  begin stk_push = 1'b1; stk_data = stk_top; end
                    OP_DROP: stk_pop = 1'b1;
`ifdef PROGRAM_STACK_SEQ_EXT_OPS_EN
                    OP_SWAP, OP_OVER: begin stk_pop = 1'b1; latch_a = 1'b1; state_d = S2; end
`endif
                    default: ;
                endcase
            end
`ifdef PROGRAM_STACK_SEQ_EXT_OPS_EN
            S2: begin
                latch_b = 1'b1;
                state_d = S3;
                if (op_q == OP_SWAP) stk_pop = 1'b1;
                else begin stk_push = 1'b1; stk_data = a_q; end
            end
            S3: begin
                stk_push = 1'b1;
                if (op_q == OP_SWAP) begin stk_data = a_q; state_d = S4; end
                else begin stk_data = b_q; state_d = RESP; end
            end
            S4: begin
                stk_push = 1'b1;
                stk_data = b_q;
                state_d  = RESP;
            end
`endif
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (!err_q && (op_q == OP_POP || op_q == OP_PEEK)) rsp_data = a_q;
                state_d = IDLE;
            end
            FAULT: fault = 1'b1;
            default: state_d = IDLE;
        endcase
        if (stk_err || (state_q == IDLE && stk_empty && depth_q != '0)) state_d = FAULT;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            a_q     <= '0;
            err_q   <= 1'b0;
            depth_q <= '0;
`ifdef PROGRAM_STACK_SEQ_EXT_OPS_EN
            b_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            // Capturing the top at accept doubles as the PEEK result.
            if (accept) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
                err_q  <= reject;
                a_q    <= stk_top;
            end else if (latch_a) begin
                a_q <= stk_top;
            end
`ifdef PROGRAM_STACK_SEQ_EXT_OPS_EN
            if (latch_b) b_q <= stk_top;
`endif
            if (stk_push) depth_q <= depth_q + DEPTH_W'(1);
            else if (stk_pop) depth_q <= depth_q - DEPTH_W'(1);
        end
    end

endmodule

// File: tb/tb_program_stack_sequencer.sv
// tb_program_stack_sequencer: random and directed commands against a queue-based stack model,
// with a behavioural stack instance attached to the strobes.
module tb_program_stack_sequencer;

    localparam int WIDTH       = 18;
    localparam int STACK_DEPTH = 64;
    localparam int DW          = $clog2(STACK_DEPTH + 1);
`ifdef PROGRAM_STACK_SEQ_EXT_OPS_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_DROP = 3'd4;
    localparam logic [2:0] OP_SWAP = 3'd5;
    localparam logic [2:0] OP_OVER = 3'd6;
    localparam logic [2:0] OP_PEEK = 3'd7;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [2:0]       cmd_op = 3'd0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             cmd_ready, rsp_valid, rsp_err, fault, stk_push, stk_pop;
    logic [WIDTH-1:0] rsp_data, stk_data;
    logic [DW-1:0]    depth;
    logic [WIDTH-1:0] stk_top = '0;
    logic             fix_empty = 1'b1;
    logic             force_empty = 1'b0;
    logic             stk_empty;
    logic             stk_err = 1'b0;

    assign stk_empty = fix_empty | force_empty;

    program_stack_sequencer #(.WIDTH(WIDTH), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .fault(fault), .depth(depth),
        .stk_top(stk_top), .stk_empty(stk_empty), .stk_err(stk_err),
        .stk_data(stk_data), .stk_push(stk_push), .stk_pop(stk_pop)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Stack instance seen by the DUT: top is valid the cycle after a strobe.
    logic [WIDTH-1:0] fix_stk[$];
    always @(posedge clock) begin
        if (reset) fix_stk.delete();
        else begin
            if (stk_push) fix_stk.push_back(stk_data);
            if (stk_pop && fix_stk.size() > 0) void'(fix_stk.pop_back());
        end
        stk_top   <= (fix_stk.size() > 0) ? fix_stk[fix_stk.size()-1] : '0;
        fix_empty <= (fix_stk.size() == 0);
    end

    typedef struct {
        bit               ready;
        bit               push;
        bit               pop;
        logic [WIDTH-1:0] sdata;
        bit               rv;
        logic [WIDTH-1:0] rdata;
        bit               rerr;
        int               depth;
        bit               flt;
        bit               chk_top;
        logic [WIDTH-1:0] top;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             cur;
    logic [WIDTH-1:0] mdl[$];
    int               n_tests = 0;
    int               n_fail = 0;

    function automatic exp_t blank(input int d);
        exp_t e;
        e.ready = 1'b0; e.push = 1'b0; e.pop = 1'b0; e.sdata = '0;
        e.rv = 1'b0; e.rdata = '0; e.rerr = 1'b0; e.depth = d; e.flt = 1'b0;
        e.chk_top = 1'b0; e.top = '0;
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, expv);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("cmd_ready", 32'(cmd_ready), 32'(cur.ready));
            check("stk_push", 32'(stk_push), 32'(cur.push));
            check("stk_pop", 32'(stk_pop), 32'(cur.pop));
            check("rsp_valid", 32'(rsp_valid), 32'(cur.rv));
            check("rsp_data", 32'(rsp_data), 32'(cur.rdata));
            check("rsp_err", 32'(rsp_err), 32'(cur.rerr));
            check("depth", 32'(depth), 32'(cur.depth));
            check("fault", 32'(fault), 32'(cur.flt));
            if (cur.push) check("stk_data", 32'(stk_data), 32'(cur.sdata));
            if (cur.chk_top) check("stack_top", 32'(stk_top), 32'(cur.top));
        end
    end

    // Issues one command at the current cycle; err_step > 0 raises stk_err during that step.
    task automatic run_cmd(input logic [2:0] op, input logic [WIDTH-1:0] d,
                           input bit lit_en, input logic [WIDTH-1:0] lit, input int err_step);
        exp_t             ent[$];
        exp_t             e;
        bit               rej;
        int               n, sz, dcur;
        bit               sp[4];
        bit               pp[4];
        logic [WIDTH-1:0] sd[4];
        logic [WIDTH-1:0] a, b, rdata;
        sz = mdl.size();
        a = (sz > 0) ? mdl[sz-1] : '0;
        b = (sz > 1) ? mdl[sz-2] : '0;
        for (int i = 0; i < 4; i++) begin sp[i] = 1'b0; pp[i] = 1'b0; sd[i] = '0; end
        n = 0;
        rdata = '0;
        case (op)
            OP_PUSH:                  rej = (sz >= STACK_DEPTH);
            OP_POP, OP_DROP, OP_PEEK: rej = (sz < 1);
            OP_DUP:                   rej = (sz < 1) || (sz >= STACK_DEPTH);
            OP_SWAP:                  rej = !EXT || (sz < 2);
            OP_OVER:                  rej = !EXT || (sz < 2) || (sz >= STACK_DEPTH);
            default:                  rej = 1'b0;
        endcase
        if (!rej) begin
            case (op)
                OP_PUSH: begin n = 1; sp[0] = 1'b1; sd[0] = d; mdl.push_back(d); end
                OP_POP:  begin n = 1; pp[0] = 1'b1; rdata = a; void'(mdl.pop_back()); end
                OP_DUP:  begin n = 1; sp[0] = 1'b1; sd[0] = a; mdl.push_back(a); end
                OP_DROP: begin n = 1; pp[0] = 1'b1; void'(mdl.pop_back()); end
                OP_SWAP: begin
                    n = 4; pp[0] = 1'b1; pp[1] = 1'b1;
                    sp[2] = 1'b1; sd[2] = a; sp[3] = 1'b1; sd[3] = b;
                    mdl[sz-1] = b; mdl[sz-2] = a;
                end
                OP_OVER: begin
                    n = 3; pp[0] = 1'b1; sp[1] = 1'b1; sd[1] = a; sp[2] = 1'b1; sd[2] = b;
                    mdl.push_back(b);
                end
                OP_PEEK: rdata = a;
                default: ;
            endcase
        end
        dcur = sz;
        e = blank(dcur); e.ready = 1'b1; ent.push_back(e);
        for (int i = 0; i < n; i++) begin
            e = blank(dcur); e.push = sp[i]; e.pop = pp[i]; e.sdata = sd[i];
            ent.push_back(e);
            dcur = dcur + int'(sp[i]) - int'(pp[i]);
        end
        e = blank(dcur); e.rv = 1'b1; e.rerr = rej; e.rdata = lit_en ? lit : rdata;
        e.chk_top = (mdl.size() > 0);
        if (e.chk_top) e.top = mdl[mdl.size()-1];
        ent.push_back(e);
        if (err_step > 0) begin
            dcur = sz;
            for (int i = 0; i < err_step; i++) dcur = dcur + int'(sp[i]) - int'(pp[i]);
            while (ent.size() > err_step + 1) void'(ent.pop_back());
            for (int i = 0; i < 4; i++) begin e = blank(dcur); e.flt = 1'b1; ent.push_back(e); end
        end
        foreach (ent[i]) exp_q.push_back(ent[i]);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(posedge clock); #1;
        for (int i = 1; i < ent.size(); i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_data  = WIDTH'($urandom());
            stk_err   = (i == err_step);
            @(posedge clock); #1;
        end
        stk_err = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        exp_t e;
        e = blank(mdl.size());
        e.ready = 1'b1;
        e.chk_top = (mdl.size() > 0);
        if (e.chk_top) e.top = mdl[mdl.size()-1];
        exp_q.push_back(e);
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom_range(0, 7));
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; cmd_valid = 1'b0; stk_err = 1'b0; force_empty = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        mdl.delete();
        idle_cycle();
    endtask

    task automatic push_rand();
        run_cmd(OP_PUSH, WIDTH'($urandom()), 1'b0, '0, -1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        logic [2:0] op;
        int r;
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        run_cmd(OP_PUSH, 18'h00011, 1'b0, '0, -1);
        run_cmd(OP_DROP, '0, 1'b0, '0, -1);

        run_cmd(OP_PUSH, 18'h00001, 1'b0, '0, -1);
        run_cmd(OP_PUSH, 18'h00002, 1'b0, '0, -1);
        run_cmd(OP_SWAP, '0, 1'b0, '0, -1);
        run_cmd(OP_POP, '0, 1'b1, EXT ? 18'h00001 : 18'h00002, -1);
        run_cmd(OP_POP, '0, 1'b1, EXT ? 18'h00002 : 18'h00001, -1);

        run_cmd(OP_PUSH, 18'h00005, 1'b0, '0, -1);
        run_cmd(OP_PUSH, 18'h00009, 1'b0, '0, -1);
        run_cmd(OP_OVER, '0, 1'b0, '0, -1);
        run_cmd(OP_POP, '0, 1'b1, EXT ? 18'h00005 : 18'h00009, -1);
        run_cmd(OP_PEEK, '0, 1'b1, EXT ? 18'h00009 : 18'h00005, -1);
        while (mdl.size() > 0) run_cmd(OP_POP, '0, 1'b0, '0, -1);

        for (int i = 0; i < 8; i++) run_cmd(3'(i), WIDTH'($urandom()), 1'b0, '0, -1);
        while (mdl.size() > 0) run_cmd(OP_POP, '0, 1'b0, '0, -1);

        while (mdl.size() < STACK_DEPTH) push_rand();
        run_cmd(OP_PUSH, 18'h3ffff, 1'b0, '0, -1);
        run_cmd(OP_DUP, '0, 1'b0, '0, -1);
        run_cmd(OP_OVER, '0, 1'b0, '0, -1);
        run_cmd(OP_PEEK, '0, 1'b0, '0, -1);
        run_cmd(OP_SWAP, '0, 1'b0, '0, -1);
        repeat (40) run_cmd(OP_POP, '0, 1'b0, '0, -1);

        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            if (mdl.size() < 3 && r < 5) op = OP_PUSH;
            else if (mdl.size() > STACK_DEPTH - 3 && r < 5) op = OP_POP;
            else op = 3'($urandom_range(0, 7));
            run_cmd(op, WIDTH'($urandom()), 1'b0, '0, -1);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        while (mdl.size() < 2) push_rand();
        if (mdl.size() >= STACK_DEPTH) run_cmd(OP_POP, '0, 1'b0, '0, -1);
`ifdef PROGRAM_STACK_SEQ_EXT_OPS_EN
        run_cmd(OP_SWAP, '0, 1'b0, '0, 2);
`else
        run_cmd(OP_PUSH, WIDTH'($urandom()), 1'b0, '0, 1);
`endif
        do_reset();

        run_cmd(OP_PUSH, 18'h00007, 1'b0, '0, -1);
        force_empty = 1'b1;
        idle_cycle();
        force_empty = 1'b0;
        repeat (2) begin
            e = blank(mdl.size());
            e.flt = 1'b1;
            exp_q.push_back(e);
            cmd_valid = 1'b1; cmd_op = OP_PUSH;
            @(posedge clock); #1;
        end
        do_reset();
        run_cmd(OP_PUSH, 18'h00021, 1'b0, '0, -1);
        run_cmd(OP_PEEK, '0, 1'b1, 18'h00021, -1);

        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
